// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the commit-stage trap/MRET sequencer.
package trap_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        UPDATE,
        REDIRECT
    } trap_state_e;

    localparam int IRQ_CODE_W = 4;

    localparam logic [IRQ_CODE_W-1:0] IRQ_CAUSE_EXT   = 4'd11;
    localparam logic [IRQ_CODE_W-1:0] IRQ_CAUSE_SW    = 4'd3;
    localparam logic [IRQ_CODE_W-1:0] IRQ_CAUSE_TIMER = 4'd7;

    // Bit positions within the {ext, sw, timer} interrupt vectors
    localparam int IRQ_EXT_BIT   = 2;
    localparam int IRQ_SW_BIT    = 1;
    localparam int IRQ_TIMER_BIT = 0;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;
    localparam logic [1:0] PRIV_M              = 2'd3;

endpackage

// File: rtl/trap_sequencer_irq_prio_enc.sv
// Combinational interrupt priority encoder: ext > sw > timer.
module irq_prio_enc
    import trap_sequencer_pkg::*;
(
    input  logic [2:0]            pending,
    input  logic [2:0]            enable,
    output logic                  hit,
    output logic [IRQ_CODE_W-1:0] code
);

    logic [2:0] active;

    assign active = pending & enable;

    always_comb begin
        hit  = |active;
        code = '0;
        if (active[IRQ_EXT_BIT]) begin
            code = IRQ_CAUSE_EXT;
        end else if (active[IRQ_SW_BIT]) begin
            code = IRQ_CAUSE_SW;
        end else if (active[IRQ_TIMER_BIT]) begin
            code = IRQ_CAUSE_TIMER;
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// Trap-entry / MRET sequencer for the commit stage: drain, CSR update strobe, held redirect.
// Optional TRAP_VECTORED_EN: interrupts use base + 4*cause when mtvec selects vectored mode.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int CAUSE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               commit_valid,
    input  logic [XLEN-1:0]    commit_pc,
    input  logic               commit_exc,
    input  logic [CAUSE_W-1:0] commit_cause,
    input  logic               commit_mret,
    input  logic [2:0]         irq_lines,
    input  logic [2:0]         csr_mie,
    input  logic               csr_mstatus_mie,
    input  logic [1:0]         cur_mode,
    input  logic [XLEN-1:0]    csr_mtvec,
    input  logic [XLEN-1:0]    csr_mepc,
    input  logic               mem_busy,
    output logic               commit_kill,
    output logic               stall_commit,
    output logic               flush_all,
    output logic               trap_req,
    output logic [XLEN-1:0]    trap_cause,
    output logic [XLEN-1:0]    trap_epc,
    output logic               mret_req,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc,
    input  logic               redirect_ready
);

    trap_state_e           state, state_next;
    logic [XLEN-1:0]       cause_q, epc_q, target_q;
    logic                  mret_q;

    logic                  irq_hit;
    logic [IRQ_CODE_W-1:0] irq_code;
    logic                  irq_take;
    logic                  accept_trap, accept_mret;
    logic [XLEN-1:0]       cause_next;
    logic [XLEN-1:0]       trap_base, trap_target;

    irq_prio_enc u_irq_prio_enc (
        .pending (irq_lines),
        .enable  (csr_mie),
        .hit     (irq_hit),
        .code    (irq_code)
    );

    assign irq_take    = commit_valid & ((cur_mode != PRIV_M) | csr_mstatus_mie) & irq_hit;
    assign accept_trap = (state == IDLE) & commit_valid & (commit_exc | irq_take);
    assign accept_mret = (state == IDLE) & commit_valid & ~commit_exc & ~irq_take & commit_mret;

    always_comb begin
        cause_next = '0;
        if (commit_exc) begin
            cause_next[CAUSE_W-1:0] = commit_cause;
        end else begin
            cause_next[IRQ_CODE_W-1:0] = irq_code;
            cause_next[XLEN-1]         = 1'b1;
        end
    end

    // Mode bits are masked off; the vectored build reinterprets them below
    assign trap_base = csr_mtvec & ~XLEN'(3);

`ifdef TRAP_VECTORED_EN
    logic [XLEN-1:0] vec_offset;

    always_comb begin
        vec_offset                   = '0;
        vec_offset[IRQ_CODE_W+1:2]   = cause_q[IRQ_CODE_W-1:0];
        trap_target                  = trap_base;
        if (cause_q[XLEN-1] && (csr_mtvec[1:0] == MTVEC_MODE_VECTORED)) begin
            trap_target = trap_base + vec_offset;
        end
    end
`else
    assign trap_target = trap_base;
`endif

    always_comb begin
        state_next     = state;
        commit_kill    = 1'b0;
        trap_req       = 1'b0;
        mret_req       = 1'b0;
        redirect_valid = 1'b0;
        case (state)
            IDLE: begin
                commit_kill = accept_trap & ~reset;
                if (accept_trap || accept_mret) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!mem_busy) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                trap_req   = ~mret_q;
                mret_req   = mret_q;
                state_next = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                if (redirect_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign stall_commit = (state != IDLE);
    assign flush_all    = (state != IDLE);
    assign trap_cause   = trap_req ? cause_q : '0;
    assign trap_epc     = trap_req ? epc_q : '0;
    assign redirect_pc  = redirect_valid ? target_q : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cause_q  <= '0;
            epc_q    <= '0;
            target_q <= '0;
            mret_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept_trap) begin
                cause_q <= cause_next;
                epc_q   <= commit_pc;
                mret_q  <= 1'b0;
            end else if (accept_mret) begin
                mret_q  <= 1'b1;
            end
            // Target is captured at the end of UPDATE so later CSR writes cannot move it
            if (state == UPDATE) begin
                target_q <= mret_q ? csr_mepc : trap_target;
            end
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: directed cases plus randomized traffic vs. a behavioural model.
module tb_trap_sequencer;

`ifdef TRAP_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        commit_valid, commit_exc, commit_mret;
    logic [63:0] commit_pc;
    logic [3:0]  commit_cause;
    logic [2:0]  irq_lines, csr_mie;
    logic        csr_mstatus_mie;
    logic [1:0]  cur_mode;
    logic [63:0] csr_mtvec, csr_mepc;
    logic        mem_busy;
    logic        commit_kill, stall_commit, flush_all, trap_req, mret_req, redirect_valid;
    logic [63:0] trap_cause, trap_epc, redirect_pc;
    logic        redirect_ready;

    trap_sequencer #(.XLEN(64), .CAUSE_W(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .commit_valid    (commit_valid),
        .commit_pc       (commit_pc),
        .commit_exc      (commit_exc),
        .commit_cause    (commit_cause),
        .commit_mret     (commit_mret),
        .irq_lines       (irq_lines),
        .csr_mie         (csr_mie),
        .csr_mstatus_mie (csr_mstatus_mie),
        .cur_mode        (cur_mode),
        .csr_mtvec       (csr_mtvec),
        .csr_mepc        (csr_mepc),
        .mem_busy        (mem_busy),
        .commit_kill     (commit_kill),
        .stall_commit    (stall_commit),
        .flush_all       (flush_all),
        .trap_req        (trap_req),
        .trap_cause      (trap_cause),
        .trap_epc        (trap_epc),
        .mret_req        (mret_req),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .redirect_ready  (redirect_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 1 = trap, 2 = mret
        logic [63:0] cause;
        logic [63:0] epc;
        int          cyc;
    } upd_t;

    upd_t        upd_q[$];
    logic [63:0] redir_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural reference: what the architecture says a commit should do
    task automatic model(input logic exc, input logic [3:0] cause, input logic mret,
                         input logic [63:0] pc, input logic [2:0] irq, input logic [2:0] mie,
                         input logic mmie, input logic [1:0] mode, input logic [63:0] mtvec,
                         input logic [63:0] mepc, output int kind, output logic [63:0] ecause,
                         output logic [63:0] eepc, output logic [63:0] etgt, output logic kill);
        logic [2:0]  p;
        int          code;
        bit          take;
        logic [63:0] base;
        p    = irq & mie;
        code = p[2] ? 11 : p[1] ? 3 : p[0] ? 7 : 0;
        take = ((mode != 2'd3) || mmie) && (p != 3'b000);
        base = mtvec & ~64'h3;
        kind = 0; ecause = '0; eepc = '0; etgt = '0; kill = 1'b0;
        if (exc) begin
            kind = 1; ecause = {60'b0, cause}; eepc = pc; etgt = base; kill = 1'b1;
        end else if (take) begin
            kind = 1; ecause = (64'h1 << 63) | 64'(code); eepc = pc; kill = 1'b1;
            etgt = base + ((VEC && mtvec[1:0] == 2'b01) ? 64'(4 * code) : 64'd0);
        end else if (mret) begin
            kind = 2; etgt = mepc;
        end
    endtask

    task automatic noise();
        commit_valid    = 1'($urandom);
        commit_exc      = 1'($urandom);
        commit_mret     = 1'($urandom);
        commit_cause    = 4'($urandom);
        commit_pc       = {$urandom, $urandom};
        irq_lines       = 3'($urandom);
        csr_mie         = 3'($urandom);
        csr_mstatus_mie = 1'($urandom);
        cur_mode        = 2'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (!stall_commit) return;
            @(posedge clk); #1;
        end
        chk("idle_timeout", {63'b0, stall_commit}, 64'd0);
    endtask

    task automatic issue(input logic exc, input logic [3:0] cause, input logic mret,
                         input logic [63:0] pc, input logic [2:0] irq, input logic [2:0] mie,
                         input logic mmie, input logic [1:0] mode, input logic [63:0] mtvec,
                         input logic [63:0] mepc, input int busy, input int rdy_dly);
        int          kind;
        logic [63:0] ec, ee, et;
        logic        kill;
        upd_t        u;
        wait_idle();
        commit_valid = 1'b1; commit_exc = exc; commit_cause = cause; commit_mret = mret;
        commit_pc = pc; irq_lines = irq; csr_mie = mie; csr_mstatus_mie = mmie;
        cur_mode = mode; csr_mtvec = mtvec; csr_mepc = mepc;
        mem_busy = 1'($urandom); redirect_ready = 1'($urandom);
        model(exc, cause, mret, pc, irq, mie, mmie, mode, mtvec, mepc, kind, ec, ee, et, kill);
        if (kind != 0) begin
            u.kind = kind; u.cause = ec; u.epc = ee; u.cyc = cyc + 2 + busy;
            upd_q.push_back(u);
            redir_q.push_back(et);
        end
        #1 chk("commit_kill", {63'b0, commit_kill}, {63'b0, kill});
        if (kind == 0) begin
            @(posedge clk); #1;
            commit_valid = 1'b0; redirect_ready = 1'b0;
            #1 chk("no_event_idle", {63'b0, stall_commit}, 64'd0);
            return;
        end
        for (int c = 1; c <= busy + 1; c++) begin
            @(posedge clk); #1;
            noise();
            mem_busy = (c <= busy);
            #1 chk("drain_ctl", {61'b0, stall_commit, flush_all, commit_kill}, 64'b110);
        end
        @(posedge clk); #1;
        noise();
        redirect_ready = 1'($urandom);
        #1 chk("update_ctl", {61'b0, stall_commit, flush_all, redirect_valid}, 64'b110);
        for (int d = 0; d <= rdy_dly; d++) begin
            @(posedge clk); #1;
            if (d < rdy_dly) begin
                noise();
                csr_mtvec = {$urandom, $urandom};
                csr_mepc  = {$urandom, $urandom};
                redirect_ready = 1'b0;
            end else begin
                commit_valid = 1'b0;
                redirect_ready = 1'b1;
            end
            #1 chk("redirect_ctl", {60'b0, redirect_valid, stall_commit, flush_all, commit_kill},
                   64'b1110);
        end
        @(posedge clk); #1;
        redirect_ready = 1'b0; commit_valid = 1'b0;
        #1 chk("back_idle", {62'b0, stall_commit, flush_all}, 64'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe or redirect
    always @(negedge clk) begin
        if (!reset) begin
            if (trap_req || mret_req) begin
                if (upd_q.size() == 0) begin
                    chk("unexpected_req", {62'b0, trap_req, mret_req}, 64'd0);
                end else begin
                    upd_t e;
                    e = upd_q.pop_front();
                    chk("req_kind", {62'b0, trap_req, mret_req}, (e.kind == 1) ? 64'b10 : 64'b01);
                    chk("req_cycle", 64'(cyc), 64'(e.cyc));
                    if (e.kind == 1) begin
                        chk("trap_cause", trap_cause, e.cause);
                        chk("trap_epc", trap_epc, e.epc);
                    end
                end
            end
            if (redirect_valid) begin
                if (redir_q.size() == 0) begin
                    chk("unexpected_redirect", {63'b0, redirect_valid}, 64'd0);
                end else begin
                    chk("redirect_pc", redirect_pc, redir_q[0]);
                    if (redirect_ready) void'(redir_q.pop_front());
                end
            end
        end
    end

    initial begin
        int causes[6] = '{0, 2, 4, 6, 8, 11};
        reset = 1'b1;
        commit_valid = 1'b1; commit_exc = 1'b1; commit_cause = 4'd2; commit_mret = 1'b0;
        commit_pc = 64'h8000_0000; irq_lines = 3'b111; csr_mie = 3'b111; csr_mstatus_mie = 1'b1;
        cur_mode = 2'd3; csr_mtvec = 64'h8000_1000; csr_mepc = 64'h0; mem_busy = 1'b0;
        redirect_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_ctl", {58'b0, commit_kill, stall_commit, flush_all, trap_req, mret_req,
            redirect_valid}, 64'd0);
        chk("reset_data", trap_cause | trap_epc | redirect_pc, 64'd0);
        commit_valid = 1'b0; redirect_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // ecall from M-mode
        issue(1, 4'd11, 0, 64'h8000_0010, 3'b000, 3'b000, 0, 2'd3, 64'h8000_1000, 64'h0, 0, 0);
        // timer and sw pending together: sw wins
        issue(0, 4'd0, 0, 64'h8000_0020, 3'b011, 3'b011, 1, 2'd3, 64'h8000_1000, 64'h0, 0, 1);
        // illegal instruction beats a pending ext irq, which follows afterwards
        issue(1, 4'd2, 0, 64'h8000_0030, 3'b100, 3'b100, 1, 2'd3, 64'h8000_1000, 64'h0, 0, 0);
        issue(0, 4'd0, 0, 64'h8000_0034, 3'b100, 3'b100, 1, 2'd3, 64'h8000_1000, 64'h0, 0, 0);
        // MRET with a long drain
        issue(0, 4'd0, 1, 64'h8000_0040, 3'b000, 3'b000, 1, 2'd3, 64'h8000_1000, 64'h8000_0044, 5, 0);
        // fetch holds off the redirect
        issue(1, 4'd8, 0, 64'h8000_0050, 3'b000, 3'b000, 0, 2'd0, 64'h8000_2000, 64'h0, 1, 4);
        // vectored-mode mtvec with ext irq
        issue(0, 4'd0, 0, 64'h8000_0060, 3'b100, 3'b100, 1, 2'd3, 64'h8000_1001, 64'h0, 0, 0);
        // M-mode with MIE clear ignores the interrupt; U-mode takes it regardless
        issue(0, 4'd0, 0, 64'h8000_0070, 3'b001, 3'b001, 0, 2'd3, 64'h8000_1000, 64'h0, 0, 0);
        issue(0, 4'd0, 0, 64'h8000_0074, 3'b001, 3'b001, 0, 2'd0, 64'h8000_1000, 64'h0, 0, 0);

        // reset during DRAIN aborts without a CSR update
        wait_idle();
        commit_valid = 1'b1; commit_exc = 1'b1; commit_cause = 4'd4; commit_mret = 1'b0;
        commit_pc = 64'h8000_0080; mem_busy = 1'b1;
        @(posedge clk); #1;
        commit_valid = 1'b0;
        @(posedge clk); #1;
        commit_valid = 1'b1; commit_exc = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("abort_ctl", {58'b0, commit_kill, stall_commit, flush_all, trap_req, mret_req,
            redirect_valid}, 64'd0);
        chk("abort_data", trap_cause | trap_epc | redirect_pc, 64'd0);
        @(posedge clk); #1;
        commit_valid = 1'b0; mem_busy = 1'b0;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk("abort_idle", {62'b0, stall_commit, flush_all}, 64'd0);

        for (int n = 0; n < 60; n++) begin
            issue(1'($urandom_range(0, 3) == 0), 4'(causes[$urandom_range(0, 5)]), 1'($urandom),
                  {32'h8000_0000, $urandom} & ~64'h3, 3'($urandom), 3'($urandom), 1'($urandom),
                  ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0, {$urandom, $urandom},
                  {$urandom, $urandom}, $urandom_range(0, 4), $urandom_range(0, 3));
        end

        repeat (5) @(posedge clk);
        #1;
        chk("sb_upd_empty", 64'(upd_q.size()), 64'd0);
        chk("sb_redir_empty", 64'(redir_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
